caliptra_imem_arbiter: RTL and testbench

- Shares the single-port IMEM SRAM between two requesters: VeeR instruction fetch (read-only) and the external loader port (write-only, driven from the C++ harness or a SoC preload path).
- External writes are buffered in a small FIFO and drained when fetch is idle.
- Drains are forced when a fetch would otherwise starve them, or when a fetch hits a pending write address.
- Sits between caliptra_top's imem_cs/imem_addr/imem_rdata and the IMEM caliptra_sram instance.

---
 rtl/caliptra_imem_arbiter_if.sv | 58 +++++
 rtl/caliptra_imem_arbiter.sv | 149 ++++++++++++++
 tb/tb_caliptra_imem_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/caliptra_imem_arbiter_if.sv
// Signal bundle for the IMEM arbiter: VeeR fetch port, external loader port,
// SRAM port and status. "slave" is the arbiter's view, "master" is the surroundings.
`ifndef CALIPTRA_IMEM_ADDR_WIDTH
`define CALIPTRA_IMEM_ADDR_WIDTH 13
`endif
`ifndef CALIPTRA_IMEM_DATA_WIDTH
`define CALIPTRA_IMEM_DATA_WIDTH 32
`endif

interface caliptra_imem_arbiter_if #(
    parameter int ADDR_W = `CALIPTRA_IMEM_ADDR_WIDTH,
    parameter int DATA_W = `CALIPTRA_IMEM_DATA_WIDTH
);
    // Handshakes: a fetch is issued in the cycle core_cs_i & core_gnt_o; the
    // requester holds core_cs_i/core_addr_i stable until then, and the data
    // returns with core_rvalid_o on the following cycle. An external write is
    // accepted in the cycle ext_we_i & ext_ready_o; ext_we_i while ext_ready_o
    // is low drops the write and sets the sticky overflow_o.
    logic              core_cs_i;
    logic [ADDR_W-1:0] core_addr_i;
    logic              core_gnt_o;
    logic              core_rvalid_o;
    logic [DATA_W-1:0] core_rdata_o;

    logic              ext_we_i;
    logic [ADDR_W-1:0] ext_addr_i;
    logic [DATA_W-1:0] ext_wdata_i;
    logic              ext_ready_o;

    logic              sram_cs_o;
    logic              sram_we_o;
    logic [ADDR_W-1:0] sram_addr_o;
    logic [DATA_W-1:0] sram_wdata_o;
    logic [DATA_W-1:0] sram_rdata_i;

    logic              busy_o;
    logic              overflow_o;

    modport slave (
        input  core_cs_i, core_addr_i,
        output core_gnt_o, core_rvalid_o, core_rdata_o,
        input  ext_we_i, ext_addr_i, ext_wdata_i,
        output ext_ready_o,
        output sram_cs_o, sram_we_o, sram_addr_o, sram_wdata_o,
        input  sram_rdata_i,
        output busy_o, overflow_o
    );

    modport master (
        output core_cs_i, core_addr_i,
        input  core_gnt_o, core_rvalid_o, core_rdata_o,
        output ext_we_i, ext_addr_i, ext_wdata_i,
        input  ext_ready_o,
        input  sram_cs_o, sram_we_o, sram_addr_o, sram_wdata_o,
        output sram_rdata_i,
        input  busy_o, overflow_o
    );
endinterface

// File: rtl/caliptra_imem_arbiter.sv
// Single-port IMEM arbiter: instruction fetch reads versus buffered external
// writes, with hazard-forced and starvation-forced write drains.
`ifndef CALIPTRA_IMEM_ADDR_WIDTH
`define CALIPTRA_IMEM_ADDR_WIDTH 13
`endif
`ifndef CALIPTRA_IMEM_DATA_WIDTH
`define CALIPTRA_IMEM_DATA_WIDTH 32
`endif

module caliptra_imem_arbiter #(
    parameter int ADDR_W     = `CALIPTRA_IMEM_ADDR_WIDTH,
    parameter int DATA_W     = `CALIPTRA_IMEM_DATA_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_STARVE = 8
) (
    input logic                    clk,
    input logic                    cptra_rst_b,
    caliptra_imem_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(MAX_STARVE + 1);
    localparam logic [CNT_W-1:0] FULL_CNT     = CNT_W'(FIFO_DEPTH);
    localparam logic [STV_W-1:0] STARVE_LIMIT = STV_W'(MAX_STARVE);

    logic [ADDR_W-1:0]     fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0]     fifo_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_vld_q;
    logic [FIFO_DEPTH-1:0] fifo_vld_d;
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic [STV_W-1:0]      starve_q;
    logic [STV_W-1:0]      starve_d;
    logic                  rvalid_q;
    logic                  overflow_q;

    logic                  fifo_ne;
    logic                  push_ready;
    logic                  push;
    logic                  drop;
    logic                  addr_hit;
    logic                  hazard;
    logic                  starve_max;
    logic                  do_write;
    logic                  do_read;
    logic [ADDR_W-1:0]     head_addr;
    logic [DATA_W-1:0]     head_data;

    assign fifo_ne    = (count_q != '0);
    assign push_ready = (count_q < FULL_CNT);
    assign push       = cptra_rst_b & bus.ext_we_i & push_ready;
    assign drop       = cptra_rst_b & bus.ext_we_i & ~push_ready;
    assign head_addr  = fifo_addr_q[rd_ptr_q];
    assign head_data  = fifo_data_q[rd_ptr_q];
    assign starve_max = (starve_q == STARVE_LIMIT);

    // A fetch must not overtake any pending write to the same word, including
    // one being accepted this very cycle.
    always_comb begin
        addr_hit = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_vld_q[i] && (fifo_addr_q[i] == bus.core_addr_i)) begin
                addr_hit = 1'b1;
            end
        end
        if (push && (bus.ext_addr_i == bus.core_addr_i)) begin
            addr_hit = 1'b1;
        end
    end

    assign hazard   = bus.core_cs_i & addr_hit;
    // Reset gates the arbitration so every SRAM/core output drops immediately.
    assign do_write = cptra_rst_b & fifo_ne & (~bus.core_cs_i | hazard | starve_max);
    assign do_read  = cptra_rst_b & ~do_write & bus.core_cs_i & ~hazard;

    always_comb begin
        fifo_vld_d = fifo_vld_q;
        if (do_write) begin
            fifo_vld_d[rd_ptr_q] = 1'b0;
        end
        if (push) begin
            fifo_vld_d[wr_ptr_q] = 1'b1;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (do_write || !fifo_ne) begin
            starve_d = '0;
        end else if (do_read && !starve_max) begin
            starve_d = starve_q + STV_W'(1);
        end
    end

    always_comb begin
        bus.sram_addr_o  = '0;
        bus.sram_wdata_o = '0;
        if (do_write) begin
            bus.sram_addr_o  = head_addr;
            bus.sram_wdata_o = head_data;
        end else if (do_read) begin
            bus.sram_addr_o  = bus.core_addr_i;
        end
    end

    assign bus.sram_cs_o     = do_write | do_read;
    assign bus.sram_we_o     = do_write;
    assign bus.core_gnt_o    = do_read;
    assign bus.core_rvalid_o = rvalid_q;
    assign bus.core_rdata_o  = rvalid_q ? bus.sram_rdata_i : '0;
    assign bus.ext_ready_o   = cptra_rst_b & push_ready;
    assign bus.busy_o        = fifo_ne;
    assign bus.overflow_o    = overflow_q;

    // Entry payloads need no reset: fifo_vld_q/count_q qualify them.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= bus.ext_addr_i;
            fifo_data_q[wr_ptr_q] <= bus.ext_wdata_i;
        end
    end

    always_ff @(posedge clk or negedge cptra_rst_b) begin
        if (!cptra_rst_b) begin
            fifo_vld_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            rvalid_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            fifo_vld_q <= fifo_vld_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_write) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q  <= count_q + CNT_W'(push) - CNT_W'(do_write);
            starve_q <= starve_d;
            rvalid_q <= do_read;
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_caliptra_imem_arbiter.sv
// Bench for caliptra_imem_arbiter: directed scenarios plus random traffic
// against a queue-based reference model and a behavioural SRAM.
module tb_caliptra_imem_arbiter;
  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int EW    = AW + DW;
  localparam int DEPTH = 4;
  localparam int MAXS  = 8;
  localparam int WORDS = 1 << AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  caliptra_imem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  caliptra_imem_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .FIFO_DEPTH(DEPTH),
    .MAX_STARVE(MAXS)
  ) dut (
    .clk        (clk),
    .cptra_rst_b(rst_n),
    .bus        (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural SRAM ----------------
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return 32'hC0DE_0000 | {{(DW-AW){1'b0}}, a};
  endfunction

  logic [DW-1:0] sram_mem     [WORDS];
  bit            sram_written [WORDS];

  always @(posedge clk) begin
    if (bus.sram_cs_o) begin
      if (bus.sram_we_o) begin
        sram_mem[bus.sram_addr_o]     <= bus.sram_wdata_o;
        sram_written[bus.sram_addr_o] <= 1'b1;
      end else begin
        bus.sram_rdata_i <= sram_written[bus.sram_addr_o] ? sram_mem[bus.sram_addr_o]
                                                          : init_val(bus.sram_addr_o);
      end
    end
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;

  logic [EW-1:0] exp_wr_q[$];
  logic [DW-1:0] exp_rd_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s got=none exp=event t=%0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  // Pending writes as a plain queue, committed memory as an array, plus the
  // starvation count and sticky overflow, evaluated once per cycle.
  logic [EW-1:0] m_fifo[$];
  logic [DW-1:0] ref_mem     [WORDS];
  bit            ref_written [WORDS];
  int            m_starve = 0;
  bit            m_ovf    = 1'b0;
  bit            m_rvalid = 1'b0;
  bit            m_gnt    = 1'b0;

  int            n_pend;
  bit            e_ready, e_push, e_hit, e_hazard, e_wr, e_rd;
  logic [EW-1:0] e_head;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_gnt",    64'(bus.core_gnt_o),    64'd0);
      check("rst_rvalid", 64'(bus.core_rvalid_o), 64'd0);
      check("rst_rdata",  64'(bus.core_rdata_o),  64'd0);
      check("rst_ready",  64'(bus.ext_ready_o),   64'd0);
      check("rst_cs",     64'(bus.sram_cs_o),     64'd0);
      check("rst_we",     64'(bus.sram_we_o),     64'd0);
      check("rst_addr",   64'(bus.sram_addr_o),   64'd0);
      check("rst_wdata",  64'(bus.sram_wdata_o),  64'd0);
      check("rst_busy",   64'(bus.busy_o),        64'd0);
      check("rst_ovf",    64'(bus.overflow_o),    64'd0);
      m_fifo.delete();
      exp_wr_q.delete();
      exp_rd_q.delete();
      m_starve = 0;
      m_ovf    = 1'b0;
      m_rvalid = 1'b0;
      m_gnt    = 1'b0;
    end else begin
      n_pend  = m_fifo.size();
      e_ready = (n_pend < DEPTH);
      e_push  = bus.ext_we_i && e_ready;
      e_hit   = 1'b0;
      foreach (m_fifo[i]) begin
        if (m_fifo[i][EW-1:DW] == bus.core_addr_i) e_hit = 1'b1;
      end
      if (e_push && (bus.ext_addr_i == bus.core_addr_i)) e_hit = 1'b1;
      e_hazard = bus.core_cs_i && e_hit;
      e_wr     = (n_pend > 0) && (!bus.core_cs_i || e_hazard || (m_starve == MAXS));
      e_rd     = !e_wr && bus.core_cs_i && !e_hazard;

      check("ext_ready", 64'(bus.ext_ready_o),   64'(e_ready));
      check("core_gnt",  64'(bus.core_gnt_o),    64'(e_rd));
      check("sram_cs",   64'(bus.sram_cs_o),     64'(e_wr || e_rd));
      check("sram_we",   64'(bus.sram_we_o),     64'(e_wr));
      check("busy",      64'(bus.busy_o),        64'(n_pend != 0));
      check("overflow",  64'(bus.overflow_o),    64'(m_ovf));
      check("rvalid",    64'(bus.core_rvalid_o), 64'(m_rvalid));
      if (!m_rvalid) check("rdata_idle", 64'(bus.core_rdata_o), 64'd0);
      if (e_rd) check("rd_addr", 64'(bus.sram_addr_o), 64'(bus.core_addr_i));
      if (!e_wr && !e_rd) begin
        check("idle_addr",  64'(bus.sram_addr_o),  64'd0);
        check("idle_wdata", 64'(bus.sram_wdata_o), 64'd0);
      end

      if (e_wr) begin
        e_head = m_fifo.pop_front();
        ref_mem[e_head[EW-1:DW]]     = e_head[DW-1:0];
        ref_written[e_head[EW-1:DW]] = 1'b1;
      end
      if (e_rd) begin
        exp_rd_q.push_back(ref_written[bus.core_addr_i] ? ref_mem[bus.core_addr_i]
                                                        : init_val(bus.core_addr_i));
      end
      if (e_push) begin
        m_fifo.push_back({bus.ext_addr_i, bus.ext_wdata_i});
        exp_wr_q.push_back({bus.ext_addr_i, bus.ext_wdata_i});
      end
      if (bus.ext_we_i && !e_ready) m_ovf = 1'b1;
      if (e_wr || n_pend == 0) m_starve = 0;
      else if (e_rd && m_starve < MAXS) m_starve++;
      m_rvalid = e_rd;
      m_gnt    = e_rd;
    end
  end

  // ---------------- monitor ----------------
  logic [EW-1:0] mon_wr;
  logic [DW-1:0] mon_rd;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.sram_cs_o && bus.sram_we_o) begin
        if (exp_wr_q.size() == 0) begin
          fail_now("sram_write_unexpected");
        end else begin
          mon_wr = exp_wr_q.pop_front();
          check("wr_addr", 64'(bus.sram_addr_o),  64'(mon_wr[EW-1:DW]));
          check("wr_data", 64'(bus.sram_wdata_o), 64'(mon_wr[DW-1:0]));
        end
      end
      if (bus.core_rvalid_o) begin
        if (exp_rd_q.size() == 0) begin
          fail_now("rvalid_unexpected");
        end else begin
          mon_rd = exp_rd_q.pop_front();
          check("rd_data", 64'(bus.core_rdata_o), 64'(mon_rd));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.core_cs_i = 1'b0;
    bus.ext_we_i  = 1'b0;
    repeat (n) tick();
  endtask

  task automatic set_ext(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.ext_we_i    = we;
    bus.ext_addr_i  = a;
    bus.ext_wdata_i = d;
  endtask

  // Hold the fetch until the model sees it granted, then drop it.
  task automatic wait_grant(input string name);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      tick();
      set_ext(1'b0, '0, '0);
      if (m_gnt) got = 1'b1;
    end
    if (!got) fail_now(name);
    bus.core_cs_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      tick();
      if (m_fifo.size() == 0) done = 1'b1;
    end
    if (!done) fail_now(name);
  endtask

  // ---------------- stimulus ----------------
  int wr_pct;

  initial begin
    bus.core_cs_i   = 1'b0;
    bus.core_addr_i = '0;
    set_ext(1'b0, '0, '0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Idle core: each push drains on the following cycle.
    for (int i = 0; i < 4; i++) begin
      set_ext(1'b1, AW'(12'h010 + i), DW'(32'hA0 + i));
      tick();
    end
    idle(4);

    // Fetch stream to a non-matching word: overflow on the 5th push, then
    // forced writes interleaved with starvation-limited grant runs.
    bus.core_cs_i   = 1'b1;
    bus.core_addr_i = 12'h100;
    for (int i = 0; i < 5; i++) begin
      set_ext(1'b1, AW'(12'h040 + i), $urandom);
      tick();
    end
    set_ext(1'b0, '0, '0);
    wait_drain("drain_starve");
    idle(2);

    // Pending write to 0x20 blocks a fetch of 0x20 until it drains.
    bus.core_cs_i   = 1'b1;
    bus.core_addr_i = 12'h100;
    set_ext(1'b1, 12'h020, 32'hDEAD);
    tick();
    set_ext(1'b0, '0, '0);
    bus.core_addr_i = 12'h020;
    wait_grant("grant_0x20");
    idle(3);

    // Same-cycle push and fetch of 0x30 with an empty FIFO.
    bus.core_cs_i   = 1'b1;
    bus.core_addr_i = 12'h030;
    set_ext(1'b1, 12'h030, 32'hBEEF_0030);
    wait_grant("grant_0x30");
    idle(3);

    // Push while popping at two entries, then a burst with no fetches.
    bus.core_cs_i   = 1'b1;
    bus.core_addr_i = 12'h100;
    set_ext(1'b1, 12'h050, 32'h5050);
    tick();
    set_ext(1'b1, 12'h051, 32'h5151);
    tick();
    bus.core_cs_i = 1'b0;
    set_ext(1'b1, 12'h052, 32'h5252);
    tick();
    set_ext(1'b0, '0, '0);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_ext(1'b1, AW'(12'h060 + i), DW'(32'h600 + i));
      tick();
    end
    idle(6);

    // Reset with three pending writes and a fetch in flight.
    bus.core_cs_i   = 1'b1;
    bus.core_addr_i = 12'h100;
    for (int i = 0; i < 3; i++) begin
      set_ext(1'b1, AW'(12'h070 + i), DW'(32'h700 + i));
      tick();
    end
    set_ext(1'b0, '0, '0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_gnt",    64'(bus.core_gnt_o),    64'd0);
    check("async_cs",     64'(bus.sram_cs_o),     64'd0);
    check("async_rvalid", 64'(bus.core_rvalid_o), 64'd0);
    check("async_busy",   64'(bus.busy_o),        64'd0);
    check("async_ovf",    64'(bus.overflow_o),    64'd0);
    bus.core_cs_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(4);

    // Random traffic with a changing write/fetch mix.
    wr_pct = 40;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) wr_pct = $urandom_range(10, 90);
      if (!(bus.core_cs_i && !m_gnt)) begin
        bus.core_cs_i   = ($urandom_range(0, 99) < 60);
        bus.core_addr_i = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(256, 300))
                                                      : AW'($urandom_range(0, 15));
      end
      set_ext(($urandom_range(0, 99) < wr_pct), AW'($urandom_range(0, 15)), $urandom);
      tick();
    end
    idle(0);
    wait_drain("final_drain");
    idle(4);

    check("wr_queue_left", 64'(exp_wr_q.size()), 64'd0);
    check("rd_queue_left", 64'(exp_rd_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
